// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-fetch bus bundle: SRAM req/addr_ok/data_ok channel plus the
// valid/ready delivery channel toward decode.
interface inst_fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        fetch_adel;

    modport master (
        output inst_req, inst_addr, fetch_valid, fetch_pc, fetch_inst, fetch_adel,
        input  inst_addr_ok, inst_data_ok, inst_rdata, fetch_ready
    );

    modport slave (
        input  inst_req, inst_addr, fetch_valid, fetch_pc, fetch_inst, fetch_adel,
        output inst_addr_ok, inst_data_ok, inst_rdata, fetch_ready
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one SRAM read at a time, buffers one
// instruction toward decode and discards work invalidated by redirects.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter int          CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    inst_fetch_ctrl_if.master      bus,
    output logic [CNT_W-1:0]       fetch_cnt,
    output logic [CNT_W-1:0]       kill_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_e;

    state_e            state_q,     state_d;
    logic [31:0]       pc_q,        pc_d;
    logic [31:0]       infl_pc_q,   infl_pc_d;
    logic              kill_q,      kill_d;
    logic              fv_q,        fv_d;
    logic [31:0]       fpc_q,       fpc_d;
    logic [31:0]       finst_q,     finst_d;
    logic              fadel_q,     fadel_d;
    logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]  kill_cnt_q,  kill_cnt_d;

    logic pc_misaligned;
    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        infl_pc_d   = infl_pc_q;
        kill_d      = kill_q;
        fv_d        = fv_q;
        fpc_d       = fpc_q;
        finst_d     = finst_q;
        fadel_d     = fadel_q;
        fetch_cnt_d = fetch_cnt_q;
        kill_cnt_d  = kill_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (redirect_valid) pc_d = redirect_pc;
                state_d = S_REQ;
            end

            S_REQ: begin
                if (pc_misaligned) begin
                    // Misaligned PC never reaches the SRAM; a redirect simply retargets.
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else begin
                        fv_d    = 1'b1;
                        fpc_d   = pc_q;
                        finst_d = 32'h0;
                        fadel_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_OUT;
                    end
                end else if (bus.inst_addr_ok) begin
                    infl_pc_d = pc_q;
                    pc_d      = redirect_valid ? redirect_pc : pc_q + 32'd4;
                    kill_d    = redirect_valid;
                    state_d   = S_WAIT;
                end else if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d   = redirect_pc;
                    kill_d = 1'b1;
                end
                if (bus.inst_data_ok) begin
                    if (kill_q || redirect_valid) begin
                        kill_d     = 1'b0;
                        kill_cnt_d = kill_cnt_q + CNT_W'(1);
                        state_d    = S_REQ;
                    end else begin
                        fv_d    = 1'b1;
                        fpc_d   = infl_pc_q;
                        finst_d = bus.inst_rdata;
                        fadel_d = 1'b0;
                        state_d = S_OUT;
                    end
                end
            end

            S_OUT: begin
                if (redirect_valid) pc_d = redirect_pc;
                // An accepted instruction alongside a redirect is the delay slot: keep it.
                if (bus.fetch_ready) begin
                    fv_d        = 1'b0;
                    fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                    state_d     = S_REQ;
                end else if (redirect_valid) begin
                    fv_d       = 1'b0;
                    kill_cnt_d = kill_cnt_q + CNT_W'(1);
                    state_d    = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            infl_pc_q   <= 32'h0;
            kill_q      <= 1'b0;
            fv_q        <= 1'b0;
            fpc_q       <= 32'h0;
            finst_q     <= 32'h0;
            fadel_q     <= 1'b0;
            fetch_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            infl_pc_q   <= infl_pc_d;
            kill_q      <= kill_d;
            fv_q        <= fv_d;
            fpc_q       <= fpc_d;
            finst_q     <= finst_d;
            fadel_q     <= fadel_d;
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign bus.inst_req    = (state_q == S_REQ) && !pc_misaligned;
    assign bus.inst_addr   = pc_q;
    assign bus.fetch_valid = fv_q;
    assign bus.fetch_pc    = fpc_q;
    assign bus.fetch_inst  = finst_q;
    assign bus.fetch_adel  = fadel_q;
    assign fetch_cnt       = fetch_cnt_q;
    assign kill_cnt        = kill_cnt_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl; the bench plays the SRAM and decode sides.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_cnt;
    logic [31:0] kill_cnt;

    inst_fetch_ctrl_if bus();

    inst_fetch_ctrl #(.RESET_PC(32'hbfc00000), .CNT_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .fetch_cnt      (fetch_cnt),
        .kill_cnt       (kill_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'ha5a50000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the request one cycle, then accept it.
    task automatic req_accept(input logic [31:0] exp_addr);
        chk("req", 32'(bus.inst_req), 32'd1);
        chk("addr", bus.inst_addr, exp_addr);
        step();
        bus.inst_addr_ok = 1'b1;
        step();
        bus.inst_addr_ok = 1'b0;
    endtask

    task automatic data_ret(input logic [31:0] a);
        step();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = mem(a);
        step();
        bus.inst_data_ok = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] exp_pc);
        chk("fv", 32'(bus.fetch_valid), 32'd1);
        chk("fpc", bus.fetch_pc, exp_pc);
        chk("finst", bus.fetch_inst, mem(exp_pc));
        chk("adel", 32'(bus.fetch_adel), 32'd0);
        bus.fetch_ready = 1'b1;
        step();
        bus.fetch_ready = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        bus.fetch_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_req", 32'(bus.inst_req), 32'd0);
        chk("rst_fv", 32'(bus.fetch_valid), 32'd0);
        chk("rst_fpc", bus.fetch_pc, 32'h0);
        chk("rst_fcnt", fetch_cnt, 32'd0);
        chk("rst_kcnt", kill_cnt, 32'd0);
        step();

        // 1: three sequential fetches
        for (int i = 0; i < 3; i++) begin
            req_accept(32'hbfc00000 + 32'(4 * i));
            data_ret(32'hbfc00000 + 32'(4 * i));
            deliver(32'hbfc00000 + 32'(4 * i));
        end
        chk("t1_fcnt", fetch_cnt, 32'd3);
        chk("t1_kcnt", kill_cnt, 32'd0);

        // 2: decode stall holds the buffer
        req_accept(32'hbfc0000c);
        data_ret(32'hbfc0000c);
        for (int i = 0; i < 5; i++) begin
            chk("t2_fv", 32'(bus.fetch_valid), 32'd1);
            chk("t2_fpc", bus.fetch_pc, 32'hbfc0000c);
            chk("t2_finst", bus.fetch_inst, mem(32'hbfc0000c));
            chk("t2_noreq", 32'(bus.inst_req), 32'd0);
            step();
        end
        deliver(32'hbfc0000c);
        chk("t2_next", bus.inst_addr, 32'hbfc00010);
        chk("t2_fcnt", fetch_cnt, 32'd4);

        // 4: redirect coincident with accept keeps the delay slot
        req_accept(32'hbfc00010);
        data_ret(32'hbfc00010);
        chk("t4_fpc", bus.fetch_pc, 32'hbfc00010);
        bus.fetch_ready = 1'b1;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'hbfc00200;
        step();
        bus.fetch_ready = 1'b0;
        redirect_valid  = 1'b0;
        chk("t4_req", 32'(bus.inst_req), 32'd1);
        chk("t4_addr", bus.inst_addr, 32'hbfc00200);
        chk("t4_kcnt", kill_cnt, 32'd0);
        chk("t4_fcnt", fetch_cnt, 32'd5);

        // 3: redirect while waiting for data kills the response
        req_accept(32'hbfc00200);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hbfc00100;
        step();
        redirect_valid = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = mem(32'hbfc00200);
        step();
        bus.inst_data_ok = 1'b0;
        chk("t3_fv", 32'(bus.fetch_valid), 32'd0);
        chk("t3_kcnt", kill_cnt, 32'd1);
        chk("t3_addr", bus.inst_addr, 32'hbfc00100);
        chk("t3_fcnt", fetch_cnt, 32'd5);

        // Redirect while buffer is stalled drops it
        req_accept(32'hbfc00100);
        data_ret(32'hbfc00100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hbfc00300;
        step();
        redirect_valid = 1'b0;
        chk("drop_fv", 32'(bus.fetch_valid), 32'd0);
        chk("drop_kcnt", kill_cnt, 32'd2);
        chk("drop_addr", bus.inst_addr, 32'hbfc00300);
        chk("drop_fcnt", fetch_cnt, 32'd5);

        // 5: misaligned redirect surfaces as address error
        redirect_valid = 1'b1;
        redirect_pc    = 32'hbfc00102;
        step();
        redirect_valid = 1'b0;
        chk("t5_noreq", 32'(bus.inst_req), 32'd0);
        step();
        chk("t5_fv", 32'(bus.fetch_valid), 32'd1);
        chk("t5_adel", 32'(bus.fetch_adel), 32'd1);
        chk("t5_fpc", bus.fetch_pc, 32'hbfc00102);
        chk("t5_finst", bus.fetch_inst, 32'h0);
        bus.fetch_ready = 1'b1;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'hbfc00400;
        step();
        bus.fetch_ready = 1'b0;
        redirect_valid  = 1'b0;
        chk("t5_addr", bus.inst_addr, 32'hbfc00400);
        chk("t5_fcnt", fetch_cnt, 32'd6);

        // 6: reset during S_WAIT, late data_ok ignored
        req_accept(32'hbfc00400);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hdeadbeef;
        step();
        chk("t6_req", 32'(bus.inst_req), 32'd1);
        chk("t6_addr", bus.inst_addr, 32'hbfc00000);
        step();
        bus.inst_data_ok = 1'b0;
        chk("t6_fv", 32'(bus.fetch_valid), 32'd0);
        chk("t6_fcnt", fetch_cnt, 32'd0);
        chk("t6_kcnt", kill_cnt, 32'd0);
        req_accept(32'hbfc00000);
        data_ret(32'hbfc00000);
        deliver(32'hbfc00000);
        chk("t6_fcnt1", fetch_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
